parking_gate_ctrl: RTL and testbench
====================================

PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 SHALL have parameter PW_DIGITS, default 2: number of password digits per entry.
REQ-002 SHALL have parameter DIGIT_W, default 2: bit width of one password digit.
REQ-003 SHALL have parameter PASSWORD, default 4'b0110: expected code, PW_DIGITS*DIGIT_W bits wide, digit 0 in the LSBs.
REQ-004 SHALL have parameter CAPACITY, default 8: maximum number of parked vehicles; CNT_W = clog2(CAPACITY+1), derived.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 1000: number of idle cycles allowed in a password state.
REQ-006 SHALL have parameters MAX_TRIES, default 3, and LOCK_CYC, default 5000: lockout threshold and lockout duration in cycles.
REQ-007 SHALL have the following ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all logic on the rising edge.
- reset  in  1  synchronous reset, active-high.
- sensor_entrance  in  1  vehicle present at the gate.
- sensor_exit  in  1  vehicle has passed through the gate.
- car_leave  in  1  one-cycle pulse: a parked vehicle left the lot.
- pw_valid  in  1  one-cycle strobe: pw_code is valid.
- pw_code  in  PW_DIGITS*DIGIT_W  entered password.
- GREEN_LED  out  1  gate open.
- RED_LED  out  1  gate closed or attention.
- full  out  1  occupancy == CAPACITY.
- locked  out  1  lockout active.
- occupancy  out  CNT_W  current vehicle count.
- state_o  out  3  encoded FSM state.

Function
REQ-008 SHALL implement a Moore FSM with states IDLE=0, WAIT_PASSWORD=1, WRONG_PASS=2, RIGHT_PASS=3, STOP=4 and LOCKED=5, driven on state_o.
REQ-009 In IDLE, SHALL go to WAIT_PASSWORD when sensor_entrance=1 and full=0; when full=1 it SHALL remain in IDLE and ignore sensor_entrance.
REQ-010 In WAIT_PASSWORD or WRONG_PASS, SHALL act on pw_valid as follows: pw_code==PASSWORD -> RIGHT_PASS, with the try counter cleared; mismatch -> WRONG_PASS, with the try counter incremented.
REQ-011 A timeout counter SHALL clear on every state entry and on every pw_valid; on reaching TIMEOUT_CYC in WAIT_PASSWORD or WRONG_PASS, the FSM SHALL go to IDLE and the try counter SHALL clear.
REQ-012 In RIGHT_PASS, on sensor_exit=1 occupancy SHALL increment; the FSM SHALL then go to STOP if sensor_entrance=1 in the same cycle, else to IDLE.
REQ-013 In STOP, a matching pw_valid SHALL go to RIGHT_PASS; a mismatch SHALL stay in STOP with no try count; STOP has no timeout.
REQ-014 A car_leave pulse SHALL decrement occupancy, saturating at 0.
REQ-015 An increment and a car_leave in the same cycle SHALL leave occupancy unchanged.
REQ-016 Occupancy SHALL never exceed CAPACITY; a gate pass while occupancy==CAPACITY SHALL not increment.
REQ-017 Outputs SHALL be registered with one cycle of latency from the state register, with these values:
- IDLE: GREEN=0, RED=0.
- WAIT_PASSWORD, STOP, LOCKED: GREEN=0, RED=1.
- WRONG_PASS: GREEN=0, RED toggling every cycle.
- RIGHT_PASS: GREEN=1, RED=0.
REQ-018 pw_valid in IDLE, RIGHT_PASS or LOCKED SHALL be ignored.

Reset
REQ-019 reset=1 SHALL, at the next clk edge and from any state (mid-operation included), force the following:
- FSM to IDLE.
- Occupancy, try counter, timeout counter and lock counter to 0.
- GREEN_LED=0, RED_LED=0, full=0, locked=0, state_o=0.
REQ-020 reset SHALL take priority over every other input in the same cycle.

Configuration
REQ-021 Macro PARKING_LOCKOUT_EN: when defined, the mismatch that brings the try counter to MAX_TRIES SHALL go to LOCKED instead of WRONG_PASS.
- In LOCKED: locked=1 and all inputs except reset and car_leave are ignored.
- After LOCK_CYC cycles: go to IDLE, try counter cleared.
REQ-022 Without PARKING_LOCKOUT_EN: LOCKED is unreachable, locked is tied to 0, and the try counter is not instantiated.

Verification
REQ-023 Bench parameters: defaults except CAPACITY=2, TIMEOUT_CYC=16, LOCK_CYC=32.
REQ-024 Reset: reset=1 for 5 cycles -> state_o=0, both LEDs 0, occupancy=0.
REQ-025 Correct entry: sensor_entrance=1, pw_valid with pw_code=4'b0110, then sensor_exit=1 -> the following responses in order:
- RIGHT_PASS with GREEN=1.
- IDLE with occupancy=1.
REQ-026 Wrong code and timeout: pw_code=4'b1100 -> WRONG_PASS with RED toggling; 16 idle cycles -> IDLE.
REQ-027 Lockout (PARKING_LOCKOUT_EN defined): 3 wrong codes -> LOCKED and locked=1; after 32 cycles -> IDLE and locked=0.
REQ-028 Full and simultaneous events: fill to 2 -> full=1 and sensor_entrance ignored; car_leave together with a gate pass -> occupancy unchanged.
REQ-029 Back-to-back and reset mid-operation: sensor_exit=1 with sensor_entrance=1 -> STOP; reset=1 in WAIT_PASSWORD -> IDLE on the next edge.

Source files
------------

// File: rtl/parking_gate_ctrl.sv
// -----------------------------------------------------------------------------
// parking_gate_ctrl
//
// Purpose:
//    Controls a parking-lot entry gate. A vehicle arriving at the gate must
//    present the correct password before the gate opens. The block also keeps
//    the lot occupancy count, which goes up on a gate pass and down on a
//    car_leave pulse. The lot refuses new arrivals while it is full.
//
// Optional feature (macro PARKING_LOCKOUT_EN):
//    When defined, MAX_TRIES consecutive wrong codes lock the gate for
//    LOCK_CYC cycles. When undefined, the LOCKED state is unreachable, locked
//    is tied low and the try counter does not exist.
//
// Ports:
//    clk              in   rising-edge clock
//    reset            in   synchronous reset, active-high
//    sensor_entrance  in   vehicle present at the gate
//    sensor_exit      in   vehicle has passed through the gate
//    car_leave        in   one-cycle pulse, a parked vehicle left the lot
//    pw_valid         in   one-cycle strobe, pw_code is valid
//    pw_code          in   entered password (digit 0 in the LSBs)
//    GREEN_LED        out  gate open (registered)
//    RED_LED          out  gate closed or attention (registered)
//    full             out  occupancy == CAPACITY (registered)
//    locked           out  lockout active (registered)
//    occupancy        out  current vehicle count
//    state_o          out  encoded FSM state
// -----------------------------------------------------------------------------
module parking_gate_ctrl #(
   parameter int                             PW_DIGITS   = 2,
   parameter int                             DIGIT_W     = 2,
   parameter logic [PW_DIGITS*DIGIT_W-1:0]   PASSWORD    = 4'b0110,
   parameter int                             CAPACITY    = 8,
   parameter int                             TIMEOUT_CYC = 1000,
   parameter int                             MAX_TRIES   = 3,
   parameter int                             LOCK_CYC    = 5000,
   localparam int                            CNT_W       = $clog2(CAPACITY + 1)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             sensor_entrance,
   input  logic                             sensor_exit,
   input  logic                             car_leave,
   input  logic                             pw_valid,
   input  logic [PW_DIGITS*DIGIT_W-1:0]     pw_code,
   output logic                             GREEN_LED,
   output logic                             RED_LED,
   output logic                             full,
   output logic                             locked,
   output logic [CNT_W-1:0]                 occupancy,
   output logic [2:0]                       state_o
);

   typedef enum logic [2:0] {
      S_IDLE          = 3'd0,
      S_WAIT_PASSWORD = 3'd1,
      S_WRONG_PASS    = 3'd2,
      S_RIGHT_PASS    = 3'd3,
      S_STOP          = 3'd4,
      S_LOCKED        = 3'd5
   } state_t;

   localparam int                TMR_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0]  CAP_VAL  = CNT_W'(CAPACITY);

   // Elaboration-time guard against degenerate configurations.
   if (PW_DIGITS < 1 || DIGIT_W < 1 || CAPACITY < 1 || TIMEOUT_CYC < 1 ||
       MAX_TRIES < 1 || LOCK_CYC < 1) begin : g_bad_params
      $error("parking_gate_ctrl: size and count parameters must be >= 1");
   end

   state_t              r_state;
   logic [TMR_W-1:0]    r_timer;
   logic                r_green;
   logic                r_red;
   logic [CNT_W-1:0]    r_occupancy;
   logic                r_full;

   logic                w_match;
   logic                w_pass;
   logic [CNT_W-1:0]    w_occ_next;

`ifdef PARKING_LOCKOUT_EN
   localparam int                TRY_W    = $clog2(MAX_TRIES + 1);
   localparam logic [TRY_W-1:0]  TRY_LAST = TRY_W'(MAX_TRIES - 1);
   localparam int                LCK_W    = $clog2(LOCK_CYC + 1);
   localparam logic [LCK_W-1:0]  LCK_LAST = LCK_W'(LOCK_CYC - 1);

   logic [TRY_W-1:0]    r_tries;
   logic [LCK_W-1:0]    r_lock_cnt;
   logic                r_locked;
`endif

   assign w_match = (pw_code == PASSWORD);
   // A gate pass is only recognised while the gate is open.
   assign w_pass  = (r_state == S_RIGHT_PASS) && sensor_exit;

   // --------------------------------------------------------------------------
   // FSM with registered outputs. The LED/locked registers decode the current
   // state register, so they follow state_o by exactly one cycle.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: every sequential register uses <= so all updates in this edge see
      // the pre-edge values; a blocking = here would create order-dependent logic.
      if (reset) begin
         r_state    <= S_IDLE;
         r_timer    <= '0;
         r_green    <= 1'b0;
         r_red      <= 1'b0;
`ifdef PARKING_LOCKOUT_EN
         r_tries    <= '0;
         r_lock_cnt <= '0;
         r_locked   <= 1'b0;
`endif
      end else begin
         // Output decode of the present state.
         r_green <= (r_state == S_RIGHT_PASS);
         case (r_state)
            S_WAIT_PASSWORD, S_STOP, S_LOCKED: r_red <= 1'b1;
            S_WRONG_PASS:                      r_red <= ~r_red;
            default:                           r_red <= 1'b0;
         endcase
`ifdef PARKING_LOCKOUT_EN
         r_locked   <= (r_state == S_LOCKED);
         r_lock_cnt <= '0;
`endif

         // The timeout counter is zero unless it is explicitly advanced below,
         // which covers both "clear on state entry" and "clear on pw_valid".
         r_timer <= '0;

         case (r_state)
            S_IDLE: begin
               if (sensor_entrance && !r_full) r_state <= S_WAIT_PASSWORD;
            end

            S_WAIT_PASSWORD, S_WRONG_PASS: begin
               if (pw_valid) begin
                  if (w_match) begin
                     r_state <= S_RIGHT_PASS;
`ifdef PARKING_LOCKOUT_EN
                     r_tries <= '0;
`endif
                  end else begin
`ifdef PARKING_LOCKOUT_EN
                     // This mismatch is the one that reaches MAX_TRIES.
                     r_state <= (r_tries == TRY_LAST) ? S_LOCKED : S_WRONG_PASS;
                     r_tries <= r_tries + 1'b1;
`else
                     r_state <= S_WRONG_PASS;
`endif
                  end
               end else if (r_timer == TMR_LAST) begin
                  r_state <= S_IDLE;
`ifdef PARKING_LOCKOUT_EN
                  r_tries <= '0;
`endif
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end

            S_RIGHT_PASS: begin
               // Back-to-back: a second vehicle already waiting goes to STOP.
               if (sensor_exit) r_state <= sensor_entrance ? S_STOP : S_IDLE;
            end

            S_STOP: begin
               // Mismatches here neither count as tries nor time out.
               if (pw_valid && w_match) r_state <= S_RIGHT_PASS;
            end

`ifdef PARKING_LOCKOUT_EN
            S_LOCKED: begin
               if (r_lock_cnt == LCK_LAST) begin
                  r_state <= S_IDLE;
                  r_tries <= '0;
               end else begin
                  r_lock_cnt <= r_lock_cnt + 1'b1;
               end
            end
`endif

            default: r_state <= S_IDLE;
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Occupancy counter. A simultaneous pass and car_leave cancel out; otherwise
   // the count saturates at 0 and at CAPACITY.
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: default assignment first so no path leaves w_occ_next unassigned,
      // which would otherwise infer a latch.
      w_occ_next = r_occupancy;
      if (w_pass && car_leave) begin
         w_occ_next = r_occupancy;
      end else if (w_pass) begin
         if (!r_full) w_occ_next = r_occupancy + 1'b1;
      end else if (car_leave && (r_occupancy != '0)) begin
         w_occ_next = r_occupancy - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_occupancy <= '0;
         r_full      <= 1'b0;
      end else begin
         r_occupancy <= w_occ_next;
         r_full      <= (w_occ_next == CAP_VAL);
      end
   end

   assign GREEN_LED = r_green;
   assign RED_LED   = r_red;
   assign full      = r_full;
   assign occupancy = r_occupancy;
   assign state_o   = r_state;
`ifdef PARKING_LOCKOUT_EN
   assign locked    = r_locked;
`else
   assign locked    = 1'b0;
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parking_gate_ctrl
//
// Self-checking bench for parking_gate_ctrl with CAPACITY=2, TIMEOUT_CYC=16,
// LOCK_CYC=32. A vector table covers reset, a correct entry and the first
// wrong code; hand-written sequences cover timeout, full lot, simultaneous
// events, back-to-back entry, reset mid-operation and lockout.
// LEDs and locked lag state_o by one cycle, which the expected values reflect.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_parking_gate_ctrl;

   localparam int CAP   = 2;
   localparam int CNT_W = $clog2(CAP + 1);

   localparam logic [3:0] GOOD = 4'b0110;
   localparam logic [3:0] BAD  = 4'b1100;

   logic             clk = 1'b0;
   logic             reset;
   logic             sensor_entrance;
   logic             sensor_exit;
   logic             car_leave;
   logic             pw_valid;
   logic [3:0]       pw_code;
   logic             GREEN_LED;
   logic             RED_LED;
   logic             full;
   logic             locked;
   logic [CNT_W-1:0] occupancy;
   logic [2:0]       state_o;

   int n_cmp  = 0;
   int n_fail = 0;

   parking_gate_ctrl #(
      .PW_DIGITS   (2),
      .DIGIT_W     (2),
      .PASSWORD    (4'b0110),
      .CAPACITY    (CAP),
      .TIMEOUT_CYC (16),
      .MAX_TRIES   (3),
      .LOCK_CYC    (32)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .sensor_entrance (sensor_entrance),
      .sensor_exit     (sensor_exit),
      .car_leave       (car_leave),
      .pw_valid        (pw_valid),
      .pw_code         (pw_code),
      .GREEN_LED       (GREEN_LED),
      .RED_LED         (RED_LED),
      .full            (full),
      .locked          (locked),
      .occupancy       (occupancy),
      .state_o         (state_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, ent, ext, lv, pv;
      logic [3:0] code;
      logic [2:0] st;
      logic       g, r;
      logic [1:0] occ;
      logic       fl;
   } vec_t;

   vec_t vecs[11];

   function automatic vec_t mk(input logic rst, ent, ext, lv, pv,
                               input logic [3:0] code, input logic [2:0] st,
                               input logic g, r, input logic [1:0] occ,
                               input logic fl);
      vec_t v;
      v.rst = rst; v.ent = ent; v.ext = ext; v.lv = lv; v.pv = pv;
      v.code = code; v.st = st; v.g = g; v.r = r; v.occ = occ; v.fl = fl;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rst, ent, ext, lv, pv, input logic [3:0] code);
      reset = rst; sensor_entrance = ent; sensor_exit = ext;
      car_leave = lv; pw_valid = pv; pw_code = code;
   endtask

   task automatic idle_inputs();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
   endtask

   initial begin
      logic exp_red;

      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);

      //              rst ent ext lv pv code | st g r occ full
      for (int i = 0; i < 5; i++)
         vecs[i] = mk(1, 0, 0, 0, 0, 4'h0,   3'd0, 0, 0, 2'd0, 0);
      vecs[5]  = mk(0, 1, 0, 0, 0, 4'h0,     3'd1, 0, 0, 2'd0, 0);
      vecs[6]  = mk(0, 1, 0, 0, 1, GOOD,     3'd3, 0, 1, 2'd0, 0);
      vecs[7]  = mk(0, 0, 1, 0, 0, 4'h0,     3'd0, 1, 0, 2'd1, 0);
      vecs[8]  = mk(0, 0, 0, 0, 1, GOOD,     3'd0, 0, 0, 2'd1, 0);
      vecs[9]  = mk(0, 1, 0, 0, 0, 4'h0,     3'd1, 0, 0, 2'd1, 0);
      vecs[10] = mk(0, 0, 0, 0, 1, BAD,      3'd2, 0, 1, 2'd1, 0);

      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].rst, vecs[i].ent, vecs[i].ext, vecs[i].lv,
               vecs[i].pv, vecs[i].code);
         tick();
         check($sformatf("vec%0d.state", i), 32'(state_o),   32'(vecs[i].st));
         check($sformatf("vec%0d.green", i), 32'(GREEN_LED), 32'(vecs[i].g));
         check($sformatf("vec%0d.red", i),   32'(RED_LED),   32'(vecs[i].r));
         check($sformatf("vec%0d.occ", i),   32'(occupancy), 32'(vecs[i].occ));
         check($sformatf("vec%0d.full", i),  32'(full),      32'(vecs[i].fl));
      end

      // Wrong code: RED toggles in WRONG_PASS, 16 idle cycles time out.
      idle_inputs();
      exp_red = 1'b1;
      for (int i = 1; i < 16; i++) begin
         tick();
         exp_red = ~exp_red;
         check($sformatf("wrong%0d.state", i), 32'(state_o), 2);
         check($sformatf("wrong%0d.red", i),   32'(RED_LED), 32'(exp_red));
      end
      tick();
      check("timeout.state", 32'(state_o), 0);
      tick();
      check("timeout.red", 32'(RED_LED), 0);

      // Fill the lot to CAPACITY, then an arrival must be ignored.
      sensor_entrance = 1'b1; tick();
      check("fill.wait", 32'(state_o), 1);
      pw_valid = 1'b1; pw_code = GOOD; tick();
      check("fill.right", 32'(state_o), 3);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0); tick();
      check("fill.idle", 32'(state_o), 0);
      check("fill.occ", 32'(occupancy), 2);
      check("fill.full", 32'(full), 1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0); tick(); tick();
      check("full.ignore_ent", 32'(state_o), 0);
      check("full.green", 32'(GREEN_LED), 0);

      // car_leave frees a slot; then a pass plus car_leave leaves it unchanged.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0); tick();
      check("leave.occ", 32'(occupancy), 1);
      check("leave.full", 32'(full), 0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0); tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, GOOD); tick();
      check("simul.right", 32'(state_o), 3);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0); tick();
      check("simul.state", 32'(state_o), 0);
      check("simul.occ", 32'(occupancy), 1);

      // Back-to-back: exit with entrance goes to STOP.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0); tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, GOOD); tick();
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0); tick();
      check("b2b.stop", 32'(state_o), 4);
      check("b2b.occ", 32'(occupancy), 2);
      idle_inputs(); tick();
      check("stop.hold", 32'(state_o), 4);
      check("stop.red", 32'(RED_LED), 1);
      check("stop.green", 32'(GREEN_LED), 0);
      pw_valid = 1'b1; pw_code = BAD; tick();
      check("stop.bad", 32'(state_o), 4);
      pw_code = GOOD; tick();
      check("stop.good", 32'(state_o), 3);
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0); tick();
      check("cap.state", 32'(state_o), 0);
      check("cap.no_inc", 32'(occupancy), 2);

      // Drain with saturation at zero.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
      tick(); tick(); tick();
      check("drain.occ", 32'(occupancy), 0);

      // Reset mid-operation beats every other input.
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0); tick();
      check("rstmid.wait", 32'(state_o), 1);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, GOOD); tick();
      check("rstmid.state", 32'(state_o), 0);
      check("rstmid.red", 32'(RED_LED), 0);
      check("rstmid.occ", 32'(occupancy), 0);
      check("rstmid.locked", 32'(locked), 0);
      idle_inputs(); tick();

      // Three wrong codes in a row.
      sensor_entrance = 1'b1; tick();
      sensor_entrance = 1'b0;
      pw_valid = 1'b1; pw_code = BAD;
      tick(); tick(); tick();
`ifdef PARKING_LOCKOUT_EN
      check("lock.state", 32'(state_o), 5);
      // Inputs other than reset and car_leave are ignored while locked.
      drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, GOOD); tick();
      check("lock.locked", 32'(locked), 1);
      for (int i = 2; i < 32; i++) begin
         tick();
         check($sformatf("lock%0d.state", i), 32'(state_o), 5);
      end
      idle_inputs(); tick();
      check("unlock.state", 32'(state_o), 0);
      check("unlock.locked_lag", 32'(locked), 1);
      tick();
      check("unlock.locked", 32'(locked), 0);
      // Try counter was cleared: one wrong code is WRONG_PASS again.
      sensor_entrance = 1'b1; tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BAD); tick();
      check("unlock.retry", 32'(state_o), 2);
`else
      check("nolock.state", 32'(state_o), 2);
      idle_inputs(); tick();
      check("nolock.locked", 32'(locked), 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
